// File: rtl/sdr_stream_reader.sv
// Job-level front end for avalon_sdr: splits a word job into batches and streams the words out.
// Optional SDR_PREFETCH_EN adds a drain buffer so the next batch is fetched while the current one drains.
module sdr_stream_reader #(
  parameter int MAX_NREAD = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             job_baseaddr,
  input  logic [29:0]             job_nwords,
  input  logic                    job_start,
  output logic                    job_busy,
  output logic                    job_done,
  output logic [31:0]             sdr_baseaddr,
  output logic [29:0]             sdr_nelems,
  output logic                    sdr_readstart,
  input  logic                    sdr_readend,
  input  logic [32*MAX_NREAD-1:0] sdr_readdata,
  output logic [31:0]             out_data,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int          IW     = (MAX_NREAD > 1) ? $clog2(MAX_NREAD) : 1;
  localparam logic [29:0] MAX_NB = 30'(MAX_NREAD);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_r, state_s;
  logic          zero_r, zero_s;
  logic [29:0]   rem_r, rem_s;
  logic [IW-1:0] idx_r, idx_s, idx_inc_s;
  logic          busy_s, done_s, start_s, valid_s;
  logic [31:0]   base_s, data_s, req_addr_s;
  logic [29:0]   nelems_s, req_rem_s, req_nb_s, drain_nb_s;
  logic          hs_s, last_s, enter_req_s;

  function automatic logic [29:0] batch_len(input logic [29:0] words);
    if (words > MAX_NB) begin
      batch_len = MAX_NB;
    end else begin
      batch_len = words;
    end
  endfunction

  assign hs_s      = out_valid & out_ready;
  assign idx_inc_s = idx_r + IW'(1);
  assign last_s    = (30'(idx_r) == (drain_nb_s - 30'd1));

`ifdef SDR_PREFETCH_EN
  logic [32*MAX_NREAD-1:0] buf_r;
  logic [29:0]             buf_nb_r;
  logic                    pending_r, pending_s;
  logic                    land_s, room_s, copy_s;

  // A landed batch is copied as soon as the buffer is empty or empties on this edge
  assign drain_nb_s = buf_nb_r;
  assign land_s     = (state_r == S_WAIT) & sdr_readend;
  assign room_s     = ~out_valid | (hs_s & last_s);
  assign copy_s     = (land_s | pending_r) & room_s;
`else
  assign drain_nb_s = sdr_nelems;
`endif

  // State register and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= S_IDLE;
      zero_r        <= 1'b0;
      rem_r         <= 30'd0;
      idx_r         <= '0;
      job_busy      <= 1'b0;
      job_done      <= 1'b0;
      sdr_baseaddr  <= 32'd0;
      sdr_nelems    <= 30'd0;
      sdr_readstart <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= 32'd0;
    end else begin
      state_r       <= state_s;
      zero_r        <= zero_s;
      rem_r         <= rem_s;
      idx_r         <= idx_s;
      job_busy      <= busy_s;
      job_done      <= done_s;
      sdr_baseaddr  <= base_s;
      sdr_nelems    <= nelems_s;
      sdr_readstart <= start_s;
      out_valid     <= valid_s;
      out_data      <= data_s;
    end
  end

`ifdef SDR_PREFETCH_EN
  // Drain buffer and pending flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_r     <= '0;
      buf_nb_r  <= 30'd0;
      pending_r <= 1'b0;
    end else begin
      pending_r <= pending_s;
      if (copy_s) begin
        buf_r    <= sdr_readdata;
        buf_nb_r <= sdr_nelems;
      end
    end
  end
`endif

  // Next-state logic; a zero-word job spends one busy cycle in DONE before the done pulse
  always_comb begin
    state_s = state_r;
    zero_s  = zero_r;
    case (state_r)
      S_IDLE: begin
        if (job_start) begin
          state_s = (job_nwords == 30'd0) ? S_DONE : S_REQ;
          zero_s  = (job_nwords == 30'd0);
        end else begin
          state_s = S_IDLE;
          zero_s  = 1'b0;
        end
      end
      S_REQ: state_s = S_WAIT;
`ifdef SDR_PREFETCH_EN
      S_WAIT: begin
        if (land_s) begin
          state_s = (copy_s && (rem_r != 30'd0)) ? S_REQ : S_DRAIN;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_DRAIN: begin
        if (copy_s) begin
          state_s = (rem_r != 30'd0) ? S_REQ : S_DRAIN;
        end else if (!pending_r && hs_s && last_s && (rem_r == 30'd0)) begin
          state_s = S_DONE;
        end else begin
          state_s = S_DRAIN;
        end
      end
`else
      S_WAIT: begin
        if (sdr_readend) begin
          state_s = S_DRAIN;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_DRAIN: begin
        if (hs_s && last_s) begin
          state_s = (rem_r == 30'd0) ? S_DONE : S_REQ;
        end else begin
          state_s = S_DRAIN;
        end
      end
`endif
      S_DONE: begin
        if (zero_r) begin
          state_s = S_DONE;
          zero_s  = 1'b0;
        end else begin
          state_s = S_IDLE;
        end
      end
      default: begin
        state_s = S_IDLE;
        zero_s  = 1'b0;
      end
    endcase
  end

  // Output and datapath next values
  always_comb begin
    enter_req_s = (state_s == S_REQ) && (state_r != S_REQ);
    if (state_r == S_IDLE) begin
      req_rem_s  = job_nwords;
      req_addr_s = job_baseaddr;
    end else begin
      req_rem_s  = rem_r;
      req_addr_s = sdr_baseaddr + {sdr_nelems, 2'b00};
    end
    req_nb_s = batch_len(req_rem_s);

    if (enter_req_s) begin
      rem_s    = req_rem_s - req_nb_s;
      base_s   = req_addr_s;
      nelems_s = req_nb_s;
    end else begin
      rem_s    = rem_r;
      base_s   = sdr_baseaddr;
      nelems_s = sdr_nelems;
    end
    start_s = enter_req_s;
    busy_s  = (state_s == S_REQ) || (state_s == S_WAIT) || (state_s == S_DRAIN) ||
              ((state_s == S_DONE) && zero_s);
    done_s  = (state_s == S_DONE) && !zero_s;

    idx_s   = idx_r;
    data_s  = out_data;
    valid_s = out_valid;
`ifdef SDR_PREFETCH_EN
    if (copy_s) begin
      idx_s   = '0;
      data_s  = sdr_readdata[31:0];
      valid_s = 1'b1;
    end else if (hs_s && last_s) begin
      valid_s = 1'b0;
    end else if (hs_s) begin
      idx_s  = idx_inc_s;
      data_s = buf_r[32*idx_inc_s +: 32];
    end else begin
      idx_s = idx_r;
    end
    if (copy_s) begin
      pending_s = 1'b0;
    end else if (land_s) begin
      pending_s = 1'b1;
    end else begin
      pending_s = pending_r;
    end
`else
    valid_s = (state_s == S_DRAIN);
    if ((state_r == S_WAIT) && sdr_readend) begin
      idx_s  = '0;
      data_s = sdr_readdata[31:0];
    end else if ((state_r == S_DRAIN) && hs_s && !last_s) begin
      idx_s  = idx_inc_s;
      data_s = sdr_readdata[32*idx_inc_s +: 32];
    end else begin
      idx_s = idx_r;
    end
`endif
  end

endmodule
